// File: rtl/fsm_pkg.sv
// Shared definitions for the FSM controller and its sequence monitor:
// output code values, monitor state encoding and a resync helper.
package fsm_pkg;

    localparam int CODE_SAFE = 0;
    localparam int CODE_A    = 1;
    localparam int CODE_B    = 2;

    typedef enum logic [1:0] {
        MON_IDLE = 2'd0,
        MON_A    = 2'd1,
        MON_B    = 2'd2
    } mon_state_t;

    // After an illegal transition the monitor follows whatever code it saw;
    // SAFE and any out-of-range code both land in MON_IDLE.
    function automatic mon_state_t resync_state(input logic is_a, input logic is_b);
        mon_state_t st;
        st = MON_IDLE;
        if (is_a) begin
            st = MON_A;
        end else if (is_b) begin
            st = MON_B;
        end
        return st;
    endfunction

endpackage

// File: rtl/seq_event_fifo.sv
// Small synchronous FIFO for completed-sequence records. The head entry is held
// in its own register so the consumer never sees a memory read mux settle.
module seq_event_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [DATA_W-1:0] r_head;

    logic              w_do_push;
    logic              w_do_pop;
    logic [PTR_W-1:0]  w_rd_ptr_inc;

    assign empty        = (r_count == '0);
    assign full         = (r_count == CNT_FULL);
    assign head_data    = r_head;
    assign w_do_pop     = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_do_push    = push & (~full | w_do_pop);
    assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end

            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_ONE;
            end

            // With two or more entries the successor is already in memory;
            // otherwise the new head can only be the entry arriving now.
            if (w_do_pop) begin
                if (r_count > CNT_ONE) begin
                    r_head <= r_mem[w_rd_ptr_inc];
                end else if (w_do_push) begin
                    r_head <= push_data;
                end
            end else if (w_do_push && empty) begin
                r_head <= push_data;
            end
        end
    end

endmodule

// File: rtl/fsm_seq_monitor.sv
// Watches the controller's code stream, flags illegal transitions and queues
// one record per completed SAFE->A->B->SAFE sequence for a downstream consumer.
module fsm_seq_monitor
    import fsm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] code_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_seq_id,
    output logic             err_sticky,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_sticky,
    output logic [1:0]       dbg_state
);

    // Handshake: the head record transfers on any clk edge where
    // evt_valid && evt_ready; evt_seq_id holds steady until that edge.

    mon_state_t       r_state;
    mon_state_t       w_next_state;
    logic [CNT_W-1:0] r_seq_cnt;
    logic             r_err_sticky;
    logic             r_ovf_sticky;
    logic [CNT_W-1:0] r_err_count;

    logic             w_is_safe;
    logic             w_is_a;
    logic             w_is_b;
    logic             w_illegal;
    logic             w_complete;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;
    logic             w_drop;
    logic [CNT_W-1:0] w_head_id;

    // Full-width compares so that e.g. 8'h101-style aliases never look legal.
    assign w_is_safe = (code_in == WIDTH'(CODE_SAFE));
    assign w_is_a    = (code_in == WIDTH'(CODE_A));
    assign w_is_b    = (code_in == WIDTH'(CODE_B));

    always_comb begin
        w_next_state = MON_IDLE;
        w_illegal    = 1'b1;
        w_complete   = 1'b0;
        case (r_state)
            MON_IDLE: begin
                if (w_is_safe) begin
                    w_next_state = MON_IDLE;
                    w_illegal    = 1'b0;
                end else if (w_is_a) begin
                    w_next_state = MON_A;
                    w_illegal    = 1'b0;
                end
            end
            MON_A: begin
                if (w_is_b) begin
                    w_next_state = MON_B;
                    w_illegal    = 1'b0;
                end
            end
            MON_B: begin
                if (w_is_safe) begin
                    w_next_state = MON_IDLE;
                    w_illegal    = 1'b0;
                    w_complete   = 1'b1;
                end
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        if (w_illegal) begin
            w_next_state = resync_state(w_is_a, w_is_b);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MON_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign w_pop  = evt_ready & ~w_fifo_empty;
    assign w_drop = w_complete & w_fifo_full & ~w_pop;

    seq_event_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (CNT_W)
    ) u_evt_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_complete),
        .push_data (r_seq_cnt),
        .pop       (w_pop),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .head_data (w_head_id)
    );

    // The ID advances even when the record is dropped, leaving a visible gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq_cnt <= '0;
        end else if (w_complete) begin
            r_seq_cnt <= r_seq_cnt + CNT_W'(1);
        end
    end

    // A new event in the clearing cycle takes priority over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
            r_ovf_sticky <= 1'b0;
        end else begin
            if (w_illegal) begin
                r_err_sticky <= 1'b1;
                if (clr_sticky) begin
                    r_err_count <= CNT_W'(1);
                end else if (r_err_count != {CNT_W{1'b1}}) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
            end else if (clr_sticky) begin
                r_err_sticky <= 1'b0;
                r_err_count  <= '0;
            end

            if (w_drop) begin
                r_ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                r_ovf_sticky <= 1'b0;
            end
        end
    end

    assign evt_valid  = ~w_fifo_empty;
    assign evt_seq_id = w_head_id;
    assign err_sticky = r_err_sticky;
    assign ovf_sticky = r_ovf_sticky;
    assign err_count  = r_err_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_fsm_seq_monitor.sv
// Bench for fsm_seq_monitor: directed vector table, multi-cycle corner cases
// and a randomized run against a queue-based reference model.
module tb_fsm_seq_monitor;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] code_in;
    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W-1:0] evt_seq_id;
    logic             err_sticky;
    logic             ovf_sticky;
    logic [CNT_W-1:0] err_count;
    logic             clr_sticky;
    logic [1:0]       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fsm_seq_monitor #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_seq_id (evt_seq_id),
        .err_sticky (err_sticky),
        .ovf_sticky (ovf_sticky),
        .err_count  (err_count),
        .clr_sticky (clr_sticky),
        .dbg_state  (dbg_state)
    );

    // Reference model: last accepted code position (0,1,2) plus a queue of IDs.
    int               m_last;
    logic [CNT_W-1:0] exp_q[$];
    int               m_seq;
    bit               m_err;
    bit               m_ovf;
    int               m_cnt;

    task automatic model_step(input logic r, input logic [WIDTH-1:0] c,
                              input logic rdy, input logic clr);
        int cv;
        bit legal;
        bit done;
        bit drop;
        if (r) begin
            m_last = 0;
            exp_q.delete();
            m_seq = 0;
            m_err = 0;
            m_ovf = 0;
            m_cnt = 0;
            return;
        end
        cv    = (c > 2) ? 99 : int'(c);
        legal = (cv == 0 && m_last != 1) || (cv <= 2 && cv == m_last + 1);
        done  = legal && cv == 0 && m_last == 2;
        drop  = 0;
        if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (done) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(CNT_W'(m_seq));
            else drop = 1;
            m_seq = (m_seq + 1) % (1 << CNT_W);
        end
        if (!legal) begin
            m_err = 1;
            m_cnt = clr ? 1 : ((m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt);
        end else if (clr) begin
            m_err = 0;
            m_cnt = 0;
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_last = (cv <= 2) ? cv : 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("mdl_valid", 32'(evt_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) check("mdl_id", 32'(evt_seq_id), 32'(exp_q[0]));
        check("mdl_err", 32'(err_sticky), 32'(m_err));
        check("mdl_ovf", 32'(ovf_sticky), 32'(m_ovf));
        check("mdl_cnt", 32'(err_count), 32'(m_cnt));
        check("mdl_state", 32'(dbg_state), 32'(m_last));
    endtask

    task automatic cycle(input logic r, input logic [WIDTH-1:0] c,
                         input logic rdy, input logic clr);
        @(negedge clk);
        rst        = r;
        code_in    = c;
        evt_ready  = rdy;
        clr_sticky = clr;
        @(posedge clk);
        model_step(r, c, rdy, clr);
        #1;
        check_model();
    endtask

    task automatic complete_seq(input logic rdy_last);
        cycle(1'b0, WIDTH'(1), 1'b0, 1'b0);
        cycle(1'b0, WIDTH'(2), 1'b0, 1'b0);
        cycle(1'b0, WIDTH'(0), rdy_last, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, WIDTH'(0), 1'b0, 1'b0);
        cycle(1'b0, WIDTH'(0), 1'b0, 1'b0);
    endtask

    typedef struct {
        logic             r;
        logic [WIDTH-1:0] code;
        logic             rdy;
        logic             clr;
        logic             ev;
        logic [CNT_W-1:0] id;
        logic             err;
        logic             ovf;
        logic [CNT_W-1:0] cnt;
        logic [1:0]       st;
    } vec_t;

    function automatic vec_t mk(int r, int c, int rdy, int clr, int ev, int id,
                                int err, int ovf, int cnt, int st);
        vec_t v;
        v.r = r[0]; v.code = WIDTH'(c); v.rdy = rdy[0]; v.clr = clr[0];
        v.ev = ev[0]; v.id = CNT_W'(id); v.err = err[0]; v.ovf = ovf[0];
        v.cnt = CNT_W'(cnt); v.st = st[1:0];
        return v;
    endfunction

    vec_t vecs[19];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [WIDTH-1:0] c;
        logic r, rdy, clr;

        rst = 1'b1; code_in = '0; evt_ready = 1'b0; clr_sticky = 1'b0;
        m_last = 0; m_seq = 0; m_err = 0; m_ovf = 0; m_cnt = 0;

        //           rst code rdy clr | ev id err ovf cnt st
        vecs[0]  = mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[5]  = mk(0, 2, 0, 0,  0, 0, 0, 0, 0, 2);
        vecs[6]  = mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 1, 0, 0,  1, 0, 0, 0, 0, 1);
        vecs[8]  = mk(0, 2, 0, 0,  1, 0, 0, 0, 0, 2);
        vecs[9]  = mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 1, 0,  1, 1, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 2, 0, 0,  0, 0, 1, 0, 1, 2);
        vecs[13] = mk(0, 0, 0, 0,  1, 2, 1, 0, 1, 0);
        vecs[14] = mk(0, 5, 1, 0,  0, 0, 1, 0, 2, 0);
        vecs[15] = mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        vecs[16] = mk(0, 3, 0, 1,  0, 0, 1, 0, 1, 0);
        vecs[17] = mk(0, 0, 0, 0,  0, 0, 1, 0, 1, 0);
        vecs[18] = mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            cycle(vecs[i].r, vecs[i].code, vecs[i].rdy, vecs[i].clr);
            check("tbl_valid", 32'(evt_valid), 32'(vecs[i].ev));
            if (vecs[i].ev) check("tbl_id", 32'(evt_seq_id), 32'(vecs[i].id));
            check("tbl_err", 32'(err_sticky), 32'(vecs[i].err));
            check("tbl_ovf", 32'(ovf_sticky), 32'(vecs[i].ovf));
            check("tbl_cnt", 32'(err_count), 32'(vecs[i].cnt));
            check("tbl_state", 32'(dbg_state), 32'(vecs[i].st));
        end

        // Overflow: five completions into a four-deep queue, then drain.
        do_reset();
        repeat (5) complete_seq(1'b0);
        check("ovf_set", 32'(ovf_sticky), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain_id", 32'(evt_seq_id), 32'(i));
            cycle(1'b0, WIDTH'(0), 1'b1, 1'b0);
        end
        check("ovf_drained", 32'(evt_valid), 32'd0);
        complete_seq(1'b0);
        check("ovf_gap_id", 32'(evt_seq_id), 32'd5);
        cycle(1'b0, WIDTH'(0), 1'b1, 1'b0);

        // Push and pop together while full.
        do_reset();
        repeat (4) complete_seq(1'b0);
        complete_seq(1'b1);
        check("simul_ovf", 32'(ovf_sticky), 32'd0);
        n = 0;
        for (int k = 0; k < 8 && evt_valid; k++) begin
            check("simul_id", 32'(evt_seq_id), 32'(k + 1));
            cycle(1'b0, WIDTH'(0), 1'b1, 1'b0);
            n++;
        end
        check("simul_occ", 32'(n), 32'd4);

        // Reset in the middle of a sequence with entries queued.
        do_reset();
        repeat (2) complete_seq(1'b0);
        cycle(1'b0, WIDTH'(0), 1'b0, 1'b0);
        cycle(1'b0, WIDTH'(1), 1'b0, 1'b0);
        cycle(1'b1, WIDTH'(2), 1'b1, 1'b1);
        check("rstmid_valid", 32'(evt_valid), 32'd0);
        check("rstmid_state", 32'(dbg_state), 32'd0);
        cycle(1'b0, WIDTH'(0), 1'b0, 1'b0);
        complete_seq(1'b0);
        check("rstmid_valid2", 32'(evt_valid), 32'd1);
        check("rstmid_id", 32'(evt_seq_id), 32'd0);

        // Error counter saturation, then clear colliding with a new error.
        do_reset();
        repeat (260) cycle(1'b0, WIDTH'(5), 1'b0, 1'b0);
        check("sat_cnt", 32'(err_count), 32'd255);
        cycle(1'b0, WIDTH'(5), 1'b0, 1'b1);
        check("clr_vs_err_cnt", 32'(err_count), 32'd1);
        check("clr_vs_err_sticky", 32'(err_sticky), 32'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 39) == 0);
            rdy = (i < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 8) begin
                if (m_last == 0) c = ($urandom_range(0, 2) == 0) ? WIDTH'(0) : WIDTH'(1);
                else if (m_last == 1) c = WIDTH'(2);
                else c = WIDTH'(0);
            end else begin
                c = WIDTH'($urandom);
            end
            cycle(r, c, rdy, clr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_seq_monitor.md
Name: fsm_seq_monitor

Overview:
- Downstream consumer of the FSM controller's output code stream (SAFE=0, A=1, B=2).
- Tracks the code sequence every cycle and checks each transition against the legal set.
- Counts completed SAFE→A→B→SAFE sequences.
- Queues one event record per completed sequence in a small FIFO, drained over a valid/ready interface; illegal transitions raise sticky error status.

Parameters:
- WIDTH, 8, width of the observed code bus; must match the controller's output width.
- CNT_W, 8, width of the sequence ID and the error counter.
- DEPTH, 4, event FIFO depth in entries; power of two, ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- code_in  input  WIDTH  controller output code, sampled every clk.
- evt_valid  output  1  event FIFO non-empty.
- evt_ready  input  1  consumer accepts the head entry when high with evt_valid.
- evt_seq_id  output  CNT_W  sequence ID of the head entry.
- err_sticky  output  1  an illegal transition was seen since the last reset or clear.
- ovf_sticky  output  1  an event was dropped because the FIFO was full.
- err_count  output  CNT_W  illegal-transition count, saturating.
- clr_sticky  input  1  one-cycle pulse; clears err_sticky, ovf_sticky and err_count.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state updates on posedge clk; rst is sampled only on posedge clk.
- Reset values: monitor state MON_IDLE; FIFO empty; evt_valid=0; evt_seq_id=0; err_sticky=0; ovf_sticky=0; err_count=0; internal seq counter=0.
- Monitor states: MON_IDLE (last code 0), MON_A (last 1), MON_B (last 2).
- Legal transitions, evaluated against code_in each cycle:
  - IDLE with code 0 → IDLE.
  - IDLE with code 1 → A.
  - A with code 2 → B.
  - B with code 0 → IDLE, and this is a completion.
- Any other (state, code_in) pair is illegal:
  - err_sticky ← 1; err_count increments, saturating at 2^CNT_W−1.
  - Next state resynchronises to code_in: 0→IDLE, 1→A, 2→B, any other value→IDLE.
  - No completion is generated.
- Completion at cycle t:
  - Record = current seq counter value, pushed at the t edge; counter increments, wrapping modulo 2^CNT_W.
  - evt_valid rises at t+1 when the FIFO was empty. No combinational fall-through.
- Pop: the head entry leaves when evt_valid && evt_ready. evt_seq_id is valid only while evt_valid=1 and is held stable until popped.
- FIFO full at completion:
  - Without a pop the same cycle: record dropped, ovf_sticky ← 1, seq counter still increments so the consumer sees an ID gap.
  - With a pop the same cycle: push accepted, occupancy unchanged, no overflow.
- Empty FIFO with push: entry becomes visible next cycle. evt_ready while empty is ignored.
- clr_sticky and a new error in the same cycle: the error wins, so err_sticky=1 and err_count=1. The same rule applies to ovf_sticky.
- rst mid-operation: discards all FIFO entries and the seq counter, and clears all status regardless of the other inputs that cycle.
- Code values ≥3 are compared on the full WIDTH and are always illegal.

Decomposition:
- Shared package fsm_pkg:
  - code constants CODE_SAFE=0, CODE_A=1, CODE_B=2;
  - typedef mon_state_t (MON_IDLE, MON_A, MON_B);
  - also imported by the controller.
- Sub-module seq_event_fifo:
  - parameters DEPTH and data width;
  - ports push/push_data/pop/full/empty/head_data;
  - synchronous active-high reset;
  - registered head output.
- Transition check, counters and sticky logic stay in fsm_seq_monitor.

Test Plan:
- Reset: assert rst 2 cycles with code_in=1 → next cycle all outputs 0, no event.
- Nominal sequence: codes 0,1,2,0 on consecutive cycles with evt_ready=0 → evt_valid=1 one cycle after the final 0, evt_seq_id=0. Repeat → second entry carries ID 1.
- Illegal transitions: code 0→2 → err_sticky=1 and err_count=1 the next cycle; state resyncs to B, so a following 0 yields a completion. Code 5 → err_count=2.
- Overflow: evt_ready=0, 5 completions with DEPTH=4 → 4 entries (IDs 0–3), ovf_sticky=1. Drain → IDs 0,1,2,3. The next completion carries ID 5.
- Simultaneous push/pop at full: evt_ready=1 on the completion cycle → ovf_sticky stays 0, occupancy stays 4.
- Reset mid-sequence: rst after codes 0,1 with 2 entries queued → FIFO empty, and the next full sequence yields ID 0.
